// File: rtl/intt_iter_core_pkg.sv
// Shared types and helpers for the iterative INTT engine.
// Holds the FSM encoding, default ring constants and bit reversal.
package intt_iter_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN
    } state_t;

    localparam int DEF_MODULUS = 7681;
    localparam int DEF_N_INV   = 7201;

    // Reverse the low 'bits' bits of x.
    function automatic int unsigned bitrev(
        input int unsigned x,
        input int unsigned bits
    );
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < bits) begin
                r = r | (((x >> i) & 1) << (bits - 1 - i));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/intt_iter_core_gs_butterfly_mod.sv
// Combinational Gentleman-Sande butterfly modulo MODULUS.
// Ports: u, v, w in (< MODULUS for u, v); u_new = u+v, v_new = (u-v)*w.
module gs_butterfly_mod #(
    parameter int WIDTH   = 16,
    parameter int MODULUS = 7681
) (
    input  logic [WIDTH-1:0] u,
    input  logic [WIDTH-1:0] v,
    input  logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] u_new,
    output logic [WIDTH-1:0] v_new
);

    localparam logic [WIDTH:0]     Q1 = (WIDTH+1)'(MODULUS);
    localparam logic [2*WIDTH-1:0] Q2 = (2*WIDTH)'(MODULUS);

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     sum_c;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_r;

    always_comb begin
        sum   = {1'b0, u} + {1'b0, v};
        sum_c = (sum >= Q1) ? sum - Q1 : sum;
        // Borrow is repaired by a single +q.
        if (u >= v) begin
            diff = {1'b0, u} - {1'b0, v};
        end else begin
            diff = {1'b0, u} + Q1 - {1'b0, v};
        end
        prod   = diff[WIDTH-1:0] * w;
        prod_r = prod % Q2;
        u_new  = sum_c[WIDTH-1:0];
        v_new  = prod_r[WIDTH-1:0];
    end

endmodule

// File: rtl/intt_iter_core.sv
// Iterative in-place GS-butterfly INTT: load N coefficients, run
// log2(N) stages with one butterfly, drain in natural order.
// Ports: clk, rst (sync, active high), scale_en, in_valid/in_ready/
// in_data, tw_addr/tw_data (1-cycle table latency), out_valid/
// out_ready/out_data/out_last, busy.
module intt_iter_core
    import intt_iter_core_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int N       = 16,
    parameter int LOGN    = 4,
    parameter int MODULUS = DEF_MODULUS,
    parameter int N_INV   = DEF_N_INV
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scale_en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic [2*LOGN-2:0]   tw_addr,
    input  logic [WIDTH-1:0]    tw_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_last,
    output logic                busy
);

    localparam logic [LOGN-1:0] LAST_K = LOGN'(N - 1);
    localparam logic [LOGN-2:0] LAST_J = (LOGN-1)'(N/2 - 1);
    localparam logic [LOGN-1:0] LAST_S = LOGN'(LOGN - 1);
    localparam logic [WIDTH-1:0] QW    = WIDTH'(MODULUS);
    localparam logic [WIDTH-1:0] NINV  = WIDTH'(N_INV);

    state_t state, state_nx;

    logic [WIDTH-1:0] mem [N];
    logic [LOGN-1:0]  cnt;
    logic [LOGN-1:0]  s;
    logic [LOGN-2:0]  j;
    logic             ph;
    logic             scale_lat;

    logic             beat;
    logic             fire;
    logic             bf_last;
    logic [WIDTH-1:0] in_red;
    logic [LOGN-1:0]  jx, mask, i0, i1;
    logic [WIDTH-1:0] bf_u, bf_v;
    logic [LOGN-1:0]  rd_idx;
    logic [WIDTH-1:0] sc_u, sc_v;
    logic [WIDTH-1:0] drain_val;

    logic             we0, we1;
    logic [LOGN-1:0]  wa0, wa1;
    logic [WIDTH-1:0] wd0, wd1;

    assign beat    = in_valid && in_ready;
    assign fire    = out_valid && out_ready;
    assign bf_last = ph && (j == LAST_J) && (s == LAST_S);
    assign in_red  = in_data % QW;
    assign busy    = (state == ST_COMPUTE) || (state == ST_DRAIN);

    // Butterfly j of stage s pairs i0 and i0 + 2^s inside its group.
    always_comb begin
        jx   = {1'b0, j};
        mask = (LOGN'(1) << s) - LOGN'(1);
        i0   = ((jx >> s) << (s + LOGN'(1))) | (jx & mask);
        i1   = i0 | (LOGN'(1) << s);
    end

    // s*(N/2)+j is just s concatenated above j.
    assign tw_addr = (state == ST_COMPUTE && !ph) ? {s, j} : '0;

    gs_butterfly_mod #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_bf (
        .u     (mem[i0]),
        .v     (mem[i1]),
        .w     (tw_data),
        .u_new (bf_u),
        .v_new (bf_v)
    );

    // Drain path: with v=0, u_new is the raw value, v_new the scaled one.
    assign rd_idx = LOGN'(bitrev(32'(cnt), LOGN));

    gs_butterfly_mod #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_scale (
        .u     (mem[rd_idx]),
        .v     ('0),
        .w     (NINV),
        .u_new (sc_u),
        .v_new (sc_v)
    );

    assign drain_val = scale_lat ? sc_v : sc_u;

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:    if (beat) state_nx = ST_LOAD;
            ST_LOAD:    if (beat && cnt == LAST_K) state_nx = ST_COMPUTE;
            ST_COMPUTE: if (bf_last) state_nx = ST_DRAIN;
            ST_DRAIN:   if (fire && out_last) state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        we0 = 1'b0;
        wa0 = '0;
        wd0 = '0;
        we1 = 1'b0;
        wa1 = '0;
        wd1 = '0;
        if (beat) begin
            we0 = 1'b1;
            wa0 = (state == ST_IDLE) ? '0 : cnt;
            wd0 = in_red;
        end
        if (state == ST_COMPUTE && ph) begin
            we0 = 1'b1;
            wa0 = i0;
            wd0 = bf_u;
            we1 = 1'b1;
            wa1 = i1;
            wd1 = bf_v;
        end
    end

    // Buffer contents survive reset; only writes are blocked.
    always_ff @(posedge clk) begin
        if (!rst && we0) mem[wa0] <= wd0;
        if (!rst && we1) mem[wa1] <= wd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b0;
            cnt       <= '0;
            s         <= '0;
            j         <= '0;
            ph        <= 1'b0;
            scale_lat <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            in_ready <= (state_nx == ST_IDLE) || (state_nx == ST_LOAD);
            unique case (state)
                ST_IDLE: begin
                    if (beat) begin
                        scale_lat <= scale_en;
                        cnt       <= LOGN'(1);
                    end
                end
                ST_LOAD: begin
                    if (beat) begin
                        cnt <= cnt + LOGN'(1);
                        if (cnt == LAST_K) begin
                            cnt <= '0;
                            s   <= '0;
                            j   <= '0;
                            ph  <= 1'b0;
                        end
                    end
                end
                ST_COMPUTE: begin
                    ph <= ~ph;
                    if (ph) begin
                        if (j == LAST_J) begin
                            j <= '0;
                            s <= bf_last ? '0 : s + LOGN'(1);
                        end else begin
                            j <= j + (LOGN-1)'(1);
                        end
                    end
                    if (bf_last) cnt <= '0;
                end
                ST_DRAIN: begin
                    if (fire && out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        cnt       <= '0;
                    end else if (!out_valid || fire) begin
                        // Prefetch the next beat so handshakes run back to back.
                        out_valid <= 1'b1;
                        out_data  <= drain_val;
                        out_last  <= (cnt == LAST_K);
                        cnt       <= cnt + LOGN'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intt_iter_core.sv
// Self-checking bench for intt_iter_core: fixed vectors, handshake
// corner cases and random blocks against a reference INTT model.
module tb_intt_iter_core;

    localparam int N    = 16;
    localparam int LOGN = 4;
    localparam longint Q    = 7681;
    localparam longint NINV = 7201;

    typedef logic [N-1:0][15:0] blk_t;

    typedef struct packed {
        blk_t a;
        logic sc;
        logic [1:0] mode;
        blk_t exp;
    } vec_t;

    logic clk = 0;
    logic rst;
    logic scale_en;
    logic in_valid;
    logic in_ready;
    logic [15:0] in_data;
    logic [2*LOGN-2:0] tw_addr;
    logic [15:0] tw_data;
    logic out_valid;
    logic out_ready;
    logic [15:0] out_data;
    logic out_last;
    logic busy;

    logic [15:0] tw_mem [0:(1<<(2*LOGN-1))-1];

    int errors = 0;
    int checks = 0;

    intt_iter_core dut (
        .clk       (clk),
        .rst       (rst),
        .scale_en  (scale_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .tw_addr   (tw_addr),
        .tw_data   (tw_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tw_data <= tw_mem[tw_addr];

    task automatic check(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Reference: plain GS INTT over the twiddle table, then bit-reversed read.
    function automatic blk_t model(input blk_t a, input bit sc);
        longint m [N];
        longint u, v, w, d, val;
        int len, i0, i1, r;
        blk_t e;
        for (int i = 0; i < N; i++) m[i] = longint'(a[i]) % Q;
        for (int st = 0; st < LOGN; st++) begin
            len = 1 << st;
            for (int jj = 0; jj < N/2; jj++) begin
                i0 = (jj / len) * 2 * len + (jj % len);
                i1 = i0 + len;
                w  = longint'(tw_mem[st*(N/2) + jj]);
                u  = m[i0];
                v  = m[i1];
                d  = (u - v + Q) % Q;
                m[i0] = (u + v) % Q;
                m[i1] = (d * w) % Q;
            end
        end
        for (int k = 0; k < N; k++) begin
            r = 0;
            for (int b = 0; b < LOGN; b++)
                if (((k >> b) & 1) == 1) r = r | (1 << (LOGN - 1 - b));
            val = m[r];
            if (sc) val = (val * NINV) % Q;
            e[k] = 16'(val);
        end
        return e;
    endfunction

    task automatic load_blk(input blk_t a, input bit sc);
        for (int i = 0; i < N; i++) begin
            int g;
            g = 0;
            in_valid = 1;
            in_data  = a[i];
            scale_en = (i == 0) ? sc : 1'($urandom_range(0, 1));
            while (!in_ready && g < 300) begin
                @(negedge clk);
                g++;
            end
            if (g >= 300) check("load_timeout", g, 0);
            @(negedge clk);
        end
        in_valid = 0;
    endtask

    // mode 0: always ready, 1: toggling, 2: random.
    task automatic drain_check(input string tag, input blk_t exp, input int mode);
        int beats, cyc;
        bit stalled;
        logic [15:0] hd;
        logic hl;
        beats = 0;
        cyc = 0;
        stalled = 0;
        hd = 0;
        hl = 0;
        while (beats < N && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check({tag, "_hold_v"}, out_valid, 1);
                check({tag, "_hold_d"}, out_data, hd);
                check({tag, "_hold_l"}, out_last, hl);
            end
            if (mode == 0) out_ready = 1;
            else if (mode == 1) out_ready = cyc[0];
            else out_ready = 1'($urandom_range(0, 1));
            stalled = 0;
            if (out_valid) begin
                if (out_ready) begin
                    check($sformatf("%s_d%0d", tag, beats), out_data, exp[beats]);
                    check($sformatf("%s_l%0d", tag, beats), out_last, beats == N-1);
                    beats++;
                end else begin
                    stalled = 1;
                    hd = out_data;
                    hl = out_last;
                end
            end
        end
        check({tag, "_beats"}, beats, N);
        @(negedge clk);
        out_ready = 0;
        check({tag, "_end_valid"}, out_valid, 0);
        check({tag, "_end_ready"}, in_ready, 1);
    endtask

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < N; i++) b[i] = 16'($urandom);
        return b;
    endfunction

    vec_t vecs [5];

    initial begin
        blk_t a, e;
        int lat, bad;
        bit sc;

        rst = 1;
        scale_en = 0;
        in_valid = 0;
        in_data = 0;
        out_ready = 0;
        for (int i = 0; i < (1 << (2*LOGN-1)); i++) tw_mem[i] = 16'd1;

        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_tw_addr", tw_addr, 0);
        rst = 0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        // Fixed vectors with twiddles all 1.
        for (int v = 0; v < 5; v++) vecs[v] = '0;
        for (int i = 0; i < N; i++) begin
            vecs[0].a[i] = (i == 0) ? 16'd1 : 16'd0;
            vecs[0].exp[i] = 16'd1;
            vecs[1].a[i] = (i == 0) ? 16'd1 : 16'd0;
            vecs[1].exp[i] = 16'd7201;
            vecs[2].a[i] = 16'd1;
            vecs[2].exp[i] = (i == 0) ? 16'd1 : 16'd0;
            vecs[3].a[i] = 16'd1;
            vecs[3].exp[i] = (i == 0) ? 16'd1 : 16'd0;
            vecs[4].a[i] = (i == 0) ? 16'd7680 : (i == 1) ? 16'd1 : 16'd0;
        end
        vecs[0].sc = 0;
        vecs[1].sc = 1;
        vecs[2].sc = 1;
        vecs[3].sc = 1;
        vecs[3].mode = 2'd1;
        vecs[4].sc = 0;
        vecs[4].exp = model(vecs[4].a, 0);

        for (int v = 0; v < 5; v++) begin
            load_blk(vecs[v].a, vecs[v].sc);
            drain_check($sformatf("vec%0d", v), vecs[v].exp, int'(vecs[v].mode));
        end

        // Random twiddle table from here on.
        for (int i = 0; i < (1 << (2*LOGN-1)); i++) tw_mem[i] = 16'($urandom);

        // Latency and ignored input during compute.
        a = rand_blk();
        e = model(a, 1);
        load_blk(a, 1);
        lat = 0;
        bad = 0;
        while (!out_valid && lat < 300) begin
            if (in_ready) bad++;
            if (!busy) bad++;
            in_valid = 1'($urandom_range(0, 1));
            in_data = 16'($urandom);
            @(negedge clk);
            lat++;
        end
        in_valid = 0;
        check("lat_first_valid", lat, 65);
        check("lat_ready_busy", bad, 0);
        drain_check("lat", e, 0);

        // Reset in the middle of compute.
        load_blk(rand_blk(), 0);
        repeat (30) @(negedge clk);
        check("mid_busy", busy, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tw", tw_addr, 0);
        @(negedge clk);
        check("mid_rst_ready2", in_ready, 1);
        a = rand_blk();
        e = model(a, 0);
        load_blk(a, 0);
        drain_check("post_rst", e, 0);

        // Random blocks with random backpressure.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < (1 << (2*LOGN-1)); i++) tw_mem[i] = 16'($urandom);
            a = rand_blk();
            sc = 1'($urandom_range(0, 1));
            e = model(a, sc);
            load_blk(a, sc);
            drain_check($sformatf("rnd%0d", t), e, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
